// File: rtl/instr_fetch.sv
// instr_fetch: MIPS32 instruction-fetch stage with the IF/ID pipeline register.
//
// Owns the program counter. Issues one instruction-memory read at a time over a
// request/ready + valid handshake. Presents the fetched word and its decoded
// fields to the decode stage.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   imem_req/addr         fetch request and address (address is always pc)
//   imem_ready            memory accepts the request this cycle
//   imem_valid/rdata      one-cycle read-data pulse and instruction word
//   stall                 decode cannot consume the ID register contents
//   redirect, pc_source   PC redirect; 01 branch, 10 jump, 11 jr, 00 ignored
//   branch_target         target used for a branch redirect
//   jr_target             register value used for a jr redirect
//   pc                    current fetch PC
//   id_valid, id_instr    ID register valid flag and fetched word
//   id_pc_plus4           address of the word in ID, plus 4
//   id_opcode/rs/rt/rd/funct/imm  decoded fields of id_instr
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  pc_source,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic        kill, kill_nxt;
    logic [31:0] skid, skid_nxt;
    logic [31:0] pc_nxt;
    logic        id_valid_nxt;
    logic [31:0] id_instr_nxt;
    logic [31:0] id_pc_plus4_nxt;

    logic        eff_redirect;
    logic        can_load;
    logic        loaded;
    logic [31:0] pc_plus4;
    logic [31:0] target_raw;
    logic [31:0] target;

    assign imem_addr   = pc;
    assign id_opcode   = id_instr[31:26];
    assign id_rs       = id_instr[25:21];
    assign id_rt       = id_instr[20:16];
    assign id_rd       = id_instr[15:11];
    assign id_funct    = id_instr[5:0];
    assign id_imm      = id_instr[15:0];

    always_comb begin
        eff_redirect = redirect && (pc_source != 2'b00);
        can_load     = !id_valid || !stall;
        pc_plus4     = pc + 32'd4;

        case (pc_source)
            2'b01:   target_raw = branch_target;
            2'b10:   target_raw = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
            2'b11:   target_raw = jr_target;
            default: target_raw = pc;
        endcase
        target = {target_raw[31:2], 2'b00};

        imem_req        = (state == FETCH) && !eff_redirect;
        state_nxt       = state;
        kill_nxt        = kill;
        skid_nxt        = skid;
        pc_nxt          = pc;
        id_valid_nxt    = id_valid;
        id_instr_nxt    = id_instr;
        id_pc_plus4_nxt = id_pc_plus4;
        loaded          = 1'b0;

        case (state)
            FETCH: begin
                if (!eff_redirect && imem_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_valid) begin
                    // A word returning alongside a redirect is stale as well.
                    if (kill || eff_redirect) begin
                        kill_nxt  = 1'b0;
                        state_nxt = FETCH;
                    end else if (can_load) begin
                        loaded       = 1'b1;
                        id_instr_nxt = imem_rdata;
                        state_nxt    = FETCH;
                    end else begin
                        skid_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else if (eff_redirect) begin
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (eff_redirect) begin
                    state_nxt = FETCH;
                end else if (can_load) begin
                    loaded       = 1'b1;
                    id_instr_nxt = skid;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase

        if (loaded) begin
            id_valid_nxt    = 1'b1;
            id_pc_plus4_nxt = pc_plus4;
            pc_nxt          = pc_plus4;
        end else if (!stall) begin
            id_valid_nxt = 1'b0;
        end

        // Redirect wins over both a load and a stalled hold.
        if (eff_redirect) begin
            pc_nxt       = target;
            id_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            kill        <= 1'b0;
            skid        <= '0;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc_plus4 <= '0;
        end else begin
            state       <= state_nxt;
            kill        <= kill_nxt;
            skid        <= skid_nxt;
            pc          <= pc_nxt;
            id_valid    <= id_valid_nxt;
            id_instr    <= id_instr_nxt;
            id_pc_plus4 <= id_pc_plus4_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
// A behavioural memory answers requests. The checks compare the DUT with the
// addresses and words that the fetch rules predict.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_ready, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [1:0]  pc_source;
    logic [31:0] branch_target, jr_target, pc;
    logic        id_valid;
    logic [31:0] id_instr, id_pc_plus4;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;

    logic        req2, valid2, idv2;
    logic [31:0] addr2, rdata2, pc2, instr2, pc42;
    logic [5:0]  op2, fn2;
    logic [4:0]  rs2, rt2, rd2;
    logic [15:0] imm2;

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .pc_source(pc_source),
        .branch_target(branch_target), .jr_target(jr_target), .pc(pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_funct(id_funct), .id_imm(id_imm)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1),
        .imem_valid(valid2), .imem_rdata(rdata2),
        .stall(1'b0), .redirect(1'b0), .pc_source(2'b00),
        .branch_target(32'h0), .jr_target(32'h0), .pc(pc2),
        .id_valid(idv2), .id_instr(instr2), .id_pc_plus4(pc42),
        .id_opcode(op2), .id_rs(rs2), .id_rt(rt2), .id_rd(rd2),
        .id_funct(fn2), .id_imm(imm2)
    );

    int checks = 0;
    int errors = 0;

    // Memory contents: a few fixed words, hashed data elsewhere.
    logic [31:0] ovr [logic [31:0]];
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory model. It samples the request late in the cycle and drives a
    // response just after the clock edge.
    int          mem_lat   = 1;
    bit          lat_rand  = 0;
    int          ready_pct = 100;
    bit          mem_pend  = 0;
    int          mem_cnt   = 0;
    logic [31:0] mem_a     = '0;
    logic [31:0] acc_q[$];
    logic        acc;
    logic [31:0] acc_a;

    initial begin
        imem_valid = 1'b0; imem_ready = 1'b1; imem_rdata = '0;
        forever begin
            @(negedge clk); #2;
            acc   = imem_req && imem_ready && rst_n;
            acc_a = imem_addr;
            @(posedge clk); #1;
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (acc) begin
                mem_pend = 1'b1;
                mem_cnt  = lat_rand ? $urandom_range(4, 1) : mem_lat;
                mem_a    = acc_a;
                acc_q.push_back(acc_a);
            end
            if (!rst_n) mem_pend = 1'b0;
            if (mem_pend) begin
                if (mem_cnt <= 1) begin
                    imem_valid = 1'b1;
                    imem_rdata = memw(mem_a);
                    mem_pend   = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            imem_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Responder for the wrap-around instance: fixed one-cycle latency.
    logic acc2;
    initial begin
        valid2 = 1'b0; rdata2 = 32'h2400_0001;
        forever begin
            @(negedge clk); #2;
            acc2 = req2 && rst_n;
            @(posedge clk); #1;
            valid2 = acc2 && rst_n;
        end
    end

    task automatic wait_idv(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!id_valid && n < 60);
        checks++;
        if (!id_valid) begin errors++; $display("FAIL %s_timeout: id_valid=%b required 1", tag, id_valid); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 0", pc); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b required 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_idv: got %b required 0", id_valid); end
        checks++; if (id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_id: got %h/%h required 0/0", id_instr, id_pc_plus4); end
        checks++; if (addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_param: got %h required fffffffc", addr2); end
        acc_q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        wait_idv("basic1");
        checks++; if (id_opcode !== 6'h00 || id_instr !== 32'h0) begin errors++; $display("FAIL basic_op1: got %h required 0", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL basic_pc4_1: got %h required 4", id_pc_plus4); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble: got %b required 0", id_valid); end
        wait_idv("basic2");
        checks++; if (id_opcode !== 6'h23) begin errors++; $display("FAIL basic_op2: got %h required 23", id_opcode); end
        checks++; if (id_rs !== 5'd1 || id_rt !== 5'd2 || id_imm !== 16'd4) begin errors++; $display("FAIL basic_fields: got rs=%0d rt=%0d imm=%0d required 1 2 4", id_rs, id_rt, id_imm); end
        checks++; if (id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL basic_pc4_2: got %h required 8", id_pc_plus4); end
        repeat (2) @(negedge clk);
        checks++;
        if (acc_q.size() < 3) begin errors++; $display("FAIL basic_addr_seq: got %0d requests required 3", acc_q.size()); end
        else if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin
            errors++; $display("FAIL basic_addr_seq: got %h %h %h required 0 4 8", acc_q[0], acc_q[1], acc_q[2]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] s_instr, s_pc4;
        wait_idv("stall");
        stall   = 1'b1;
        s_instr = id_instr;
        s_pc4   = id_pc_plus4;
        checks++; if (s_instr !== memw(s_pc4 - 32'd4)) begin errors++; $display("FAIL stall_word: got %h required %h", s_instr, memw(s_pc4 - 32'd4)); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (id_valid !== 1'b1 || id_instr !== s_instr || id_pc_plus4 !== s_pc4) begin
                errors++; $display("FAIL stall_hold%0d: got %b/%h/%h required 1/%h/%h", i, id_valid, id_instr, id_pc_plus4, s_instr, s_pc4);
            end
        end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b required 0", imem_req); end
        checks++; if (pc !== s_pc4) begin errors++; $display("FAIL stall_pc: got %h required %h", pc, s_pc4); end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_instr !== memw(s_pc4) || id_pc_plus4 !== s_pc4 + 32'd4) begin
            errors++; $display("FAIL stall_skid: got %b/%h/%h required 1/%h/%h", id_valid, id_instr, id_pc_plus4, memw(s_pc4), s_pc4 + 32'd4);
        end
        checks++; if (pc !== s_pc4 + 32'd4) begin errors++; $display("FAIL stall_pc_adv: got %h required %h", pc, s_pc4 + 32'd4); end
    endtask

    task automatic test_branch();
        int n = 0;
        int n0;
        mem_lat = 5;
        do begin @(negedge clk); n++; end while (!(imem_req && imem_ready) && n < 60);
        @(negedge clk);
        redirect = 1'b1; pc_source = 2'b01; branch_target = 32'h100;
        n0 = acc_q.size();
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL branch_pc: got %h required 100", pc); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL branch_idv: got %b required 0", id_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL branch_wait_req: got %b required 0", imem_req); end
        wait_idv("branch");
        checks++;
        if (id_instr !== memw(32'h100) || id_pc_plus4 !== 32'h104) begin
            errors++; $display("FAIL branch_first: got %h/%h required %h/104", id_instr, id_pc_plus4, memw(32'h100));
        end
        checks++;
        if (acc_q.size() <= n0 || acc_q[n0] !== 32'h100) begin
            errors++; $display("FAIL branch_next_addr: got %0d requests required addr 100 next", acc_q.size());
        end
        mem_lat = 1;
    endtask

    task automatic test_jump();
        stall = 1'b1;
        redirect = 1'b1; pc_source = 2'b01; branch_target = 32'h1000_0004;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (pc !== 32'h1000_0004) begin errors++; $display("FAIL jump_setup_pc: got %h required 10000004", pc); end
        wait_idv("jump");
        checks++;
        if (id_instr !== 32'h0800_0040 || id_pc_plus4 !== 32'h1000_0008) begin
            errors++; $display("FAIL jump_id: got %h/%h required 08000040/10000008", id_instr, id_pc_plus4);
        end
        redirect = 1'b1; pc_source = 2'b10;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump_pc: got %h required 10000100", pc); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jump_idv: got %b required 0", id_valid); end
    endtask

    task automatic test_jr();
        wait_idv("jr");
        redirect = 1'b1; pc_source = 2'b11; jr_target = 32'h203;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jr_pc: got %h required 200", pc); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jr_idv_stall: got %b required 0", id_valid); end
    endtask

    task automatic test_nop_redirect();
        wait_idv("nop");
        checks++; if (id_instr !== memw(32'h200)) begin errors++; $display("FAIL nop_word: got %h required %h", id_instr, memw(32'h200)); end
        redirect = 1'b1; pc_source = 2'b00; branch_target = 32'hDEAD_BEE0; jr_target = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (id_valid !== 1'b1 || pc !== 32'h204) begin
                errors++; $display("FAIL nop_redirect%0d: got idv=%b pc=%h required 1/204", i, id_valid, pc);
            end
        end
        redirect = 1'b0; stall = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_addr, m_instr, m_pc4, t, p_bt, p_jr;
        logic        p_idv, p_stall, p_red, m_valid;
        logic [1:0]  p_src;
        int          loads = 0;
        @(posedge clk); #3 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        lat_rand = 1; ready_pct = 70;
        exp_addr = '0; m_instr = '0; m_pc4 = '0;
        p_idv = 0; p_stall = 0; p_red = 0; p_src = '0; p_bt = '0; p_jr = '0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            m_valid = 1'b0;
            if (p_red && p_src != 2'b00) begin
                case (p_src)
                    2'b01:   t = p_bt;
                    2'b10:   t = {m_pc4[31:28], m_instr[25:0], 2'b00};
                    default: t = p_jr;
                endcase
                exp_addr = t & 32'hFFFF_FFFC;
                checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rnd_redirect_idv c%0d: got %b required 0", cyc, id_valid); end
            end else if (p_idv && p_stall) begin
                m_valid = 1'b1;
                checks++;
                if (id_valid !== 1'b1 || id_instr !== m_instr || id_pc_plus4 !== m_pc4) begin
                    errors++; $display("FAIL rnd_hold c%0d: got %b/%h/%h required 1/%h/%h", cyc, id_valid, id_instr, id_pc_plus4, m_instr, m_pc4);
                end
            end else if (id_valid) begin
                m_valid = 1'b1;
                checks++;
                if (id_instr !== memw(exp_addr) || id_pc_plus4 !== exp_addr + 32'd4) begin
                    errors++; $display("FAIL rnd_load c%0d: got %h/%h required %h/%h", cyc, id_instr, id_pc_plus4, memw(exp_addr), exp_addr + 32'd4);
                end
                m_instr  = memw(exp_addr);
                m_pc4    = exp_addr + 32'd4;
                exp_addr = exp_addr + 32'd4;
                loads++;
            end
            checks++;
            if (pc !== exp_addr || imem_addr !== exp_addr) begin
                errors++; $display("FAIL rnd_pc c%0d: got %h/%h required %h", cyc, pc, imem_addr, exp_addr);
            end
            checks++;
            if (id_opcode !== m_instr[31:26] || id_rs !== m_instr[25:21] || id_rt !== m_instr[20:16] ||
                id_rd !== m_instr[15:11] || id_funct !== m_instr[5:0] || id_imm !== m_instr[15:0]) begin
                errors++; $display("FAIL rnd_fields c%0d: got instr %h required %h", cyc, id_instr, m_instr);
            end
            checks++;
            if (imem_req && (mem_pend || imem_valid)) begin
                errors++; $display("FAIL rnd_one_outstanding c%0d: got req=1 required 0", cyc);
            end
            p_idv   = m_valid;
            p_stall = ($urandom_range(99) < 30);
            p_red   = ($urandom_range(99) < 6);
            p_src   = 2'($urandom);
            p_bt    = ($urandom_range(3) == 0) ? 32'hFFFF_FFFD : $urandom;
            p_jr    = $urandom;
            stall = p_stall; redirect = p_red; pc_source = p_src;
            branch_target = p_bt; jr_target = p_jr;
        end
        stall = 1'b0; redirect = 1'b0;
        checks++; if (loads < 50) begin errors++; $display("FAIL rnd_progress: got %0d loads required >= 50", loads); end
        lat_rand = 0; ready_pct = 100;
    endtask

    task automatic test_wrap();
        int n = 0;
        @(posedge clk); #3 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL midreset: got pc=%h idv=%b required 0/0", pc, id_valid); end
        checks++; if (pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc: got %h required fffffffc", pc2); end
        @(posedge clk); #3 rst_n = 1'b1;
        do begin @(negedge clk); n++; end while (!idv2 && n < 20);
        checks++; if (idv2 !== 1'b1) begin errors++; $display("FAIL wrap_timeout: got %b required 1", idv2); end
        checks++; if (pc2 !== 32'h0 || pc42 !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h/%h required 0/0", pc2, pc42); end
        checks++; if (instr2 !== 32'h2400_0001) begin errors++; $display("FAIL wrap_word: got %h required 24000001", instr2); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; pc_source = 2'b00;
        branch_target = '0; jr_target = '0;
        ovr[32'h0000_0000] = 32'h0000_0000;
        ovr[32'h0000_0004] = 32'h8C22_0004;
        ovr[32'h1000_0004] = 32'h0800_0040;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_jump();
        test_jr();
        test_nop_redirect();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
